fir_mac_seq_ctrl: RTL



---
 rtl/fir_ctrl_pkg.sv | 24 ++
 rtl/fir_mac_seq_ctrl_if.sv | 44 ++++
 rtl/fir_tap_counter.sv | 37 +++
 rtl/fir_mac_seq_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR MAC sequence controller.
// Default geometry, FSM state encoding and pipeline alignment latencies.
package fir_ctrl_pkg;

    localparam int LP_NUM_TAP  = 10;
    localparam int LP_NUM_BANK = 4;
    localparam int LP_TAP_AW   = 4;
    localparam int LP_BANK_AW  = 2;
    localparam int LP_DATA_W   = 16;

    // Read data arrives one cycle after the address; the product one cycle later.
    localparam int LP_SRAM_RD_LAT = 1;
    localparam int LP_MUL_LAT     = 1;
    localparam int LP_DRAIN_LEN   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UPDATE = 3'd1,
        ST_RD     = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

endpackage

// File: rtl/fir_mac_seq_ctrl_if.sv
// Sample-strobe / coefficient-update side and SRAM/MAC control side of the controller.
// master drives the i* signals, slave (the controller) drives the o* signals.
interface fir_mac_seq_ctrl_if
    import fir_ctrl_pkg::*;
#(
    parameter int P_NUM_BANK = LP_NUM_BANK,
    parameter int P_TAP_AW   = LP_TAP_AW,
    parameter int P_BANK_AW  = LP_BANK_AW,
    parameter int P_DATA_W   = LP_DATA_W
);

    logic                          iEnSample600k;
    logic                          iCoeffUpdateFlag;
    logic                          iCsnRam;
    logic                          iWrnRam;
    logic [P_BANK_AW+P_TAP_AW-1:0] iAddrRam;
    logic [P_DATA_W-1:0]           iWtDtRam;

    logic [P_NUM_BANK-1:0]         oCsnRam;
    logic                          oWrnRam;
    logic [P_TAP_AW-1:0]           oAddrRam;
    logic [P_DATA_W-1:0]           oWtDtRam;
    logic [P_TAP_AW-1:0]           oTapIdx;
    logic                          oEnDelay;
    logic                          oAccClr;
    logic                          oEnMul;
    logic                          oEnAddAcc;
    logic                          oOutValid;
    logic                          oBusy;
    logic                          oOverrun;

    modport master (
        output iEnSample600k, iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWtDtRam,
        input  oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oTapIdx, oEnDelay, oAccClr,
               oEnMul, oEnAddAcc, oOutValid, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample600k, iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWtDtRam,
        output oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oTapIdx, oEnDelay, oAccClr,
               oEnMul, oEnAddAcc, oOutValid, oBusy, oOverrun
    );

endinterface

// File: rtl/fir_tap_counter.sv
// Tap counter 0..P_NUM_TAP-1 with synchronous clear, enable and a last-tap flag.
module fir_tap_counter #(
    parameter int P_NUM_TAP = 10,
    parameter int P_TAP_AW  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    output logic [P_TAP_AW-1:0] cnt_o,
    output logic                last_o
);

    logic [P_TAP_AW-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == P_TAP_AW'(P_NUM_TAP - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + P_TAP_AW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_mac_seq_ctrl.sv
// FIR MAC sequence controller: per-sample tap read sweep over all coefficient banks,
// latency-aligned MAC enables and output strobe, plus registered coefficient-write decode.
module fir_mac_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int P_NUM_TAP  = LP_NUM_TAP,
    parameter int P_NUM_BANK = LP_NUM_BANK,
    parameter int P_TAP_AW   = LP_TAP_AW,
    parameter int P_BANK_AW  = LP_BANK_AW,
    parameter int P_DATA_W   = LP_DATA_W
) (
    input  logic               iClk12M,
    input  logic               iRsn,
    fir_mac_seq_ctrl_if.slave  bus
);

    localparam int DRAIN_W = $clog2(LP_DRAIN_LEN) + 1;

    state_e                 state_q, state_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic                   overrun_q, overrun_d;
    logic [LP_SRAM_RD_LAT-1:0] mul_pipe_q;
    logic [LP_MUL_LAT-1:0]  add_pipe_q;
    logic [P_NUM_BANK-1:0]  upd_csn_q, upd_csn_d;
    logic                   upd_wrn_q, upd_wrn_d;
    logic [P_TAP_AW-1:0]    upd_addr_q, upd_addr_d;
    logic [P_DATA_W-1:0]    wdata_q;

    logic                   rd_active, busy, en_mul;
    logic [P_TAP_AW-1:0]    rd_cnt, idx_cnt;
    logic                   rd_last, idx_last;
    logic [P_TAP_AW-1:0]    wr_tap;
    logic [P_BANK_AW-1:0]   wr_bank;

    assign rd_active = (state_q == ST_RD);
    assign busy      = (state_q == ST_RD) || (state_q == ST_DRAIN) || (state_q == ST_OUT);
    assign en_mul    = mul_pipe_q[LP_SRAM_RD_LAT-1];
    assign wr_tap    = bus.iAddrRam[P_TAP_AW-1:0];
    assign wr_bank   = bus.iAddrRam[P_TAP_AW +: P_BANK_AW];

    fir_tap_counter #(.P_NUM_TAP(P_NUM_TAP), .P_TAP_AW(P_TAP_AW)) u_rd_cnt (
        .clk_i  (iClk12M),
        .rst_ni (iRsn),
        .clr_i  (~rd_active),
        .en_i   (rd_active),
        .cnt_o  (rd_cnt),
        .last_o (rd_last)
    );

    // Tap index follows the read address one SRAM latency later by counting on the multiplier enable.
    fir_tap_counter #(.P_NUM_TAP(P_NUM_TAP), .P_TAP_AW(P_TAP_AW)) u_idx_cnt (
        .clk_i  (iClk12M),
        .rst_ni (iRsn),
        .clr_i  (~en_mul),
        .en_i   (en_mul),
        .cnt_o  (idx_cnt),
        .last_o (idx_last)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        overrun_d = overrun_q | (bus.iEnSample600k & busy);
        unique case (state_q)
            ST_IDLE: begin
                if (bus.iCoeffUpdateFlag)   state_d = ST_UPDATE;
                else if (bus.iEnSample600k) state_d = ST_RD;
            end
            ST_UPDATE: begin
                if (!bus.iCoeffUpdateFlag) state_d = ST_IDLE;
            end
            ST_RD: begin
                if (rd_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(LP_DRAIN_LEN - 1)) begin
                    drain_d = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                state_d = bus.iCoeffUpdateFlag ? ST_UPDATE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range bank or tap keeps every bank deselected.
    always_comb begin
        upd_csn_d  = '1;
        upd_wrn_d  = 1'b1;
        upd_addr_d = '0;
        if (state_q == ST_UPDATE && bus.iCoeffUpdateFlag) begin
            upd_wrn_d  = bus.iWrnRam;
            upd_addr_d = wr_tap;
            if (int'(wr_tap) < P_NUM_TAP && int'(wr_bank) < P_NUM_BANK) begin
                for (int b = 0; b < P_NUM_BANK; b++) begin
                    upd_csn_d[b] = bus.iCsnRam | (int'(wr_bank) != b);
                end
            end
        end
    end

    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            overrun_q  <= 1'b0;
            mul_pipe_q <= '0;
            add_pipe_q <= '0;
            upd_csn_q  <= '1;
            upd_wrn_q  <= 1'b1;
            upd_addr_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            overrun_q  <= overrun_d;
            for (int i = LP_SRAM_RD_LAT - 1; i > 0; i--) mul_pipe_q[i] <= mul_pipe_q[i-1];
            mul_pipe_q[0] <= rd_active;
            for (int i = LP_MUL_LAT - 1; i > 0; i--) add_pipe_q[i] <= add_pipe_q[i-1];
            add_pipe_q[0] <= en_mul;
            upd_csn_q  <= upd_csn_d;
            upd_wrn_q  <= upd_wrn_d;
            upd_addr_q <= upd_addr_d;
            wdata_q    <= bus.iWtDtRam;
        end
    end

    // The last tap reaches the multiplier exactly while the sequence drains.
    always_ff @(posedge iClk12M) begin
        if (iRsn && en_mul && idx_last) assert (state_q == ST_DRAIN);
    end

    assign bus.oCsnRam   = rd_active ? '0   : upd_csn_q;
    assign bus.oWrnRam   = rd_active ? 1'b1 : upd_wrn_q;
    assign bus.oAddrRam  = rd_active ? rd_cnt : upd_addr_q;
    assign bus.oWtDtRam  = wdata_q;
    assign bus.oTapIdx   = idx_cnt;
    assign bus.oEnDelay  = rd_active && (rd_cnt == '0);
    assign bus.oAccClr   = rd_active && (rd_cnt == '0);
    assign bus.oEnMul    = en_mul;
    assign bus.oEnAddAcc = add_pipe_q[LP_MUL_LAT-1];
    assign bus.oOutValid = (state_q == ST_OUT);
    assign bus.oBusy     = busy;
    assign bus.oOverrun  = overrun_q;

endmodule
